// File: rtl/sfx_pkg.sv
// Shared constants and types for the sfx register bank: default sizes, the
// special register indices, and the R15 update-source encoding.
package sfx_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_NUM_RD   = 2;

  // R12 is the loop counter, R13 the loop target, R15 the program counter.
  localparam int IDX_LOOP_CNT = 12;
  localparam int IDX_LOOP_TGT = 13;
  localparam int IDX_PC       = 15;

  // Listed from lowest to highest priority.
  typedef enum logic [1:0] {
    PC_SRC_HOLD  = 2'd0,
    PC_SRC_INC   = 2'd1,
    PC_SRC_LOOP  = 2'd2,
    PC_SRC_WRITE = 2'd3
  } pc_src_e;

endpackage

// File: rtl/sfx_pc_unit.sv
// Program counter (R15), loop counter (R12) and the LOOP branch decision.
// Explicit writes arrive already lane-merged from the bank.
module sfx_pc_unit
  import sfx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_inc,
  input  logic              loop_en,
  input  logic              cchld,
  input  logic              wr_pc,
  input  logic              wr_cnt,
  input  logic [DATA_W-1:0] wr_value,
  input  logic [DATA_W-1:0] tgt,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] cnt,
  output logic              loop_taken
);

  logic              loop_go;
  logic              taken;
  logic [DATA_W-1:0] cnt_dec;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] cnt_next;
  pc_src_e           pc_src;

  // The branch decision always uses the decremented pre-edge count, even if
  // software overwrites R12 on the same edge.
  assign loop_go = loop_en && !cchld;
  assign cnt_dec = cnt - DATA_W'(1);
  assign taken   = loop_go && (cnt_dec != '0);

  always_comb begin
    pc_src = PC_SRC_HOLD;
    if (wr_pc) begin
      pc_src = PC_SRC_WRITE;
    end else if (taken) begin
      pc_src = PC_SRC_LOOP;
    end else if (pc_inc && !cchld) begin
      pc_src = PC_SRC_INC;
    end
  end

  always_comb begin
    pc_next = pc;
    case (pc_src)
      PC_SRC_WRITE: pc_next = wr_value;
      PC_SRC_LOOP:  pc_next = tgt;
      PC_SRC_INC:   pc_next = pc + DATA_W'(1);
      default:      pc_next = pc;
    endcase
  end

  always_comb begin
    cnt_next = cnt;
    if (wr_cnt) begin
      cnt_next = wr_value;
    end else if (loop_go) begin
      cnt_next = cnt_dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      cnt        <= '0;
      loop_taken <= 1'b0;
    end else begin
      pc         <= pc_next;
      cnt        <= cnt_next;
      loop_taken <= taken;
    end
  end

endmodule

// File: rtl/sfx_gpr_bank.sv
// General-purpose register bank with byte-lane writes, multi-port reads and
// hardware PC/LOOP support. Define SFX_GPR_BANK_FWD_EN for same-cycle write forwarding.
module sfx_gpr_bank
  import sfx_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = DEF_NUM_RD,
  localparam int SEL_W    = $clog2(NUM_REGS),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [BE_W-1:0]          wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_inc,
  input  logic                     loop_en,
  input  logic                     cchld,
  input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0]        pc,
  output logic                     loop_taken
);

  logic [DATA_W-1:0] regs_view [NUM_REGS];
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] cnt_q;
  logic              wr_hit;
  logic              wr_pc;
  logic              wr_cnt;

  assign wr_hit = wr_en && (32'(wr_sel) < NUM_REGS);
  assign wr_pc  = wr_hit && (wr_sel == SEL_W'(IDX_PC));
  assign wr_cnt = wr_hit && (wr_sel == SEL_W'(IDX_LOOP_CNT));

  for (genvar b = 0; b < BE_W; b++) begin : g_lane
    assign be_mask[b*8 +: 8] = {8{wr_be[b]}};
  end

  // Every write, special registers included, is a read-modify-write of the
  // target so that disabled lanes keep their stored bytes.
  assign wr_old    = wr_hit ? regs_view[wr_sel] : '0;
  assign wr_merged = (wr_old & ~be_mask) | (wr_data & be_mask);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == IDX_PC) begin : g_pc
      assign regs_view[g] = pc_q;
    end else if (g == IDX_LOOP_CNT) begin : g_cnt
      assign regs_view[g] = cnt_q;
    end else begin : g_gpr
      logic [DATA_W-1:0] q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (wr_hit && (wr_sel == SEL_W'(g))) begin
          q <= wr_merged;
        end
      end

      assign regs_view[g] = q;
    end
  end

  sfx_pc_unit #(
    .DATA_W(DATA_W)
  ) u_pc_unit (
    .clk       (clk),
    .reset     (reset),
    .pc_inc    (pc_inc),
    .loop_en   (loop_en),
    .cchld     (cchld),
    .wr_pc     (wr_pc),
    .wr_cnt    (wr_cnt),
    .wr_value  (wr_merged),
    .tgt       (regs_view[IDX_LOOP_TGT]),
    .pc        (pc_q),
    .cnt       (cnt_q),
    .loop_taken(loop_taken)
  );

  assign pc = pc_q;

  // Forwarding only covers explicit writes; PC/counter auto-updates are
  // visible after the edge like any other stored state.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;

    assign sel = rd_sel[p*SEL_W +: SEL_W];

    always_comb begin
      data = '0;
      if (32'(sel) < NUM_REGS) begin
        data = regs_view[sel];
      end
`ifdef SFX_GPR_BANK_FWD_EN
      if (wr_hit && (sel == wr_sel)) begin
        data = wr_merged;
      end
`endif
    end

    assign rd_data[p*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_sfx_gpr_bank.sv
// Scoreboard bench for sfx_gpr_bank: stimulus queues expected outputs, and a
// monitor compares them against the DUT at the falling edge.
module tb_sfx_gpr_bank;

  localparam int DW  = 16;
  localparam int NR  = 16;
  localparam int NRD = 2;
  localparam int SW  = 4;

  logic              clk     = 1'b0;
  logic              reset   = 1'b1;
  logic              wr_en   = 1'b0;
  logic [SW-1:0]     wr_sel  = '0;
  logic [1:0]        wr_be   = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              pc_inc  = 1'b0;
  logic              loop_en = 1'b0;
  logic              cchld   = 1'b0;
  logic [NRD*SW-1:0] rd_sel  = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [DW-1:0]     pc;
  logic              loop_taken;

  int cycle_count = 0;
  int checks      = 0;
  int passes      = 0;

  typedef enum int {K_RD0, K_RD1, K_PC, K_LT} kind_e;

  typedef struct {
    int            cyc;
    kind_e         kind;
    logic [DW-1:0] val;
    string         name;
  } exp_t;

  exp_t sb[$];

  sfx_gpr_bank #(
    .DATA_W  (DW),
    .NUM_REGS(NR),
    .NUM_RD  (NRD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_be     (wr_be),
    .wr_data   (wr_data),
    .pc_inc    (pc_inc),
    .loop_en   (loop_en),
    .cchld     (cchld),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .pc        (pc),
    .loop_taken(loop_taken)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input kind_e kind, input logic [DW-1:0] val);
    exp_t e;
    e.cyc  = cycle_count;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic set_rd(input logic [SW-1:0] s0, input logic [SW-1:0] s1);
    rd_sel = {s1, s0};
  endtask

  // One clock of stimulus; strobes drop back to idle after the edge.
  task automatic apply_stimulus(input logic we, input logic [SW-1:0] sel, input logic [1:0] be,
                                input logic [DW-1:0] d, input logic inc, input logic lp,
                                input logic hold);
    wr_en   = we;
    wr_sel  = sel;
    wr_be   = be;
    wr_data = d;
    pc_inc  = inc;
    loop_en = lp;
    cchld   = hold;
    tick();
    wr_en   = 1'b0;
    pc_inc  = 1'b0;
    loop_en = 1'b0;
    cchld   = 1'b0;
  endtask

  task automatic check_output(input exp_t e);
    logic [DW-1:0] act;
    case (e.kind)
      K_RD0:   act = rd_data[DW-1:0];
      K_RD1:   act = rd_data[2*DW-1:DW];
      K_PC:    act = pc;
      default: act = {{(DW-1){1'b0}}, loop_taken};
    endcase
    checks++;
    if (act === e.val) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)", e.name, act, e.val, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle_count) begin
      check_output(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    set_rd(4'd4, 4'd12);
    repeat (2) tick();
    expect_out("reset_pc", K_PC, 16'h0000);
    expect_out("reset_lt", K_LT, 16'h0000);
    expect_out("reset_r4", K_RD0, 16'h0000);
    expect_out("reset_r12", K_RD1, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    expect_out("release_pc", K_PC, 16'h0000);
    expect_out("release_lt", K_LT, 16'h0000);

    // Byte-lane writes to R4
    apply_stimulus(1'b1, 4'd4, 2'b01, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    expect_out("r4_low_lane", K_RD0, 16'h00A5);
    apply_stimulus(1'b1, 4'd4, 2'b10, 16'h3C00, 1'b0, 1'b0, 1'b0);
    expect_out("r4_merged", K_RD0, 16'h3CA5);

    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0);
    expect_out("pc_inc_1", K_PC, 16'h0001);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0);
    expect_out("pc_inc_2", K_PC, 16'h0002);

    // Three-iteration loop starting at R12=3
    apply_stimulus(1'b1, 4'd12, 2'b11, 16'd3, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'd13, 2'b11, 16'h0100, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'd15, 2'b11, 16'h0200, 1'b0, 1'b0, 1'b0);
    expect_out("loop_setup_pc", K_PC, 16'h0200);
    expect_out("loop_setup_r12", K_RD1, 16'h0003);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0);
    expect_out("loop1_pc", K_PC, 16'h0100);
    expect_out("loop1_lt", K_LT, 16'h0001);
    expect_out("loop1_r12", K_RD1, 16'h0002);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0);
    expect_out("loop2_pc", K_PC, 16'h0100);
    expect_out("loop2_lt", K_LT, 16'h0001);
    expect_out("loop2_r12", K_RD1, 16'h0001);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0);
    expect_out("loop3_pc", K_PC, 16'h0101);
    expect_out("loop3_lt", K_LT, 16'h0000);
    expect_out("loop3_r12", K_RD1, 16'h0000);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("idle_pc_hold", K_PC, 16'h0101);
    expect_out("idle_lt", K_LT, 16'h0000);

    // Counter wraps 0 -> 0xFFFF and the loop is taken
    apply_stimulus(1'b1, 4'd13, 2'b11, 16'h0ABC, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0);
    expect_out("wrap_r12", K_RD1, 16'hFFFF);
    expect_out("wrap_pc", K_PC, 16'h0ABC);
    expect_out("wrap_lt", K_LT, 16'h0001);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("wrap_lt_clear", K_LT, 16'h0000);

    // PC wrap, then explicit write beating pc_inc on the same edge
    apply_stimulus(1'b1, 4'd15, 2'b11, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    expect_out("pc_max", K_PC, 16'hFFFF);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0);
    expect_out("pc_wrap", K_PC, 16'h0000);
    apply_stimulus(1'b1, 4'd15, 2'b11, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'd15, 2'b11, 16'h1234, 1'b1, 1'b0, 1'b0);
    expect_out("pc_write_wins", K_PC, 16'h1234);

    // Loop target comes from R13 before a same-edge write
    set_rd(4'd13, 4'd12);
    apply_stimulus(1'b1, 4'd13, 2'b11, 16'h0777, 1'b0, 1'b1, 1'b0);
    expect_out("r13_old_target", K_PC, 16'h0ABC);
    expect_out("r13_new_value", K_RD0, 16'h0777);
    expect_out("r13_r12_dec", K_RD1, 16'hFFFE);

    // R12 write wins, branch still decided by decremented old R12
    apply_stimulus(1'b1, 4'd12, 2'b11, 16'h0001, 1'b0, 1'b1, 1'b0);
    expect_out("r12_write_pc", K_PC, 16'h0777);
    expect_out("r12_write_val", K_RD1, 16'h0001);
    expect_out("r12_write_lt", K_LT, 16'h0001);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("pre_hold_lt", K_LT, 16'h0000);

    // Cache hold freezes PC/loop but not explicit writes
    set_rd(4'd5, 4'd12);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(i == 1, 4'd5, 2'b11, 16'h0007, 1'b1, 1'b1, 1'b1);
      expect_out("hold_pc", K_PC, 16'h0777);
      expect_out("hold_r12", K_RD1, 16'h0001);
      expect_out("hold_lt", K_LT, 16'h0000);
      expect_out("hold_r5", K_RD0, (i >= 1) ? 16'h0007 : 16'h0000);
    end

    apply_stimulus(1'b1, 4'd15, 2'b01, 16'h12AB, 1'b0, 1'b0, 1'b0);
    expect_out("pc_low_lane", K_PC, 16'h07AB);

    // Asynchronous reset in the middle of a loop
    set_rd(4'd4, 4'd12);
    apply_stimulus(1'b1, 4'd12, 2'b11, 16'd5, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'd13, 2'b11, 16'h0300, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0);
    expect_out("mid_loop_pc", K_PC, 16'h0300);
    expect_out("mid_loop_lt", K_LT, 16'h0001);
    expect_out("mid_loop_r12", K_RD1, 16'h0004);
    loop_en = 1'b1;
    pc_inc  = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    expect_out("async_rst_pc", K_PC, 16'h0000);
    expect_out("async_rst_lt", K_LT, 16'h0000);
    expect_out("async_rst_r4", K_RD0, 16'h0000);
    expect_out("async_rst_r12", K_RD1, 16'h0000);
    tick();
    loop_en = 1'b0;
    pc_inc  = 1'b0;
    reset   = 1'b0;
    tick();
    expect_out("post_rst_pc", K_PC, 16'h0000);

    // Same-cycle read of a register being written
    set_rd(4'd7, 4'd12);
    wr_en   = 1'b1;
    wr_sel  = 4'd7;
    wr_be   = 2'b11;
    wr_data = 16'h55AA;
    #1;
`ifdef SFX_GPR_BANK_FWD_EN
    expect_out("fwd_same_cycle", K_RD0, 16'h55AA);
`else
    expect_out("no_fwd_same_cycle", K_RD0, 16'h0000);
`endif
    tick();
    wr_en = 1'b0;
    expect_out("r7_after_write", K_RD0, 16'h55AA);

    repeat (3) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("[TB] FAIL %s: never compared, expected 0x%04h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
